// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The master modport is the upstream word source; the slave modport is the serializer.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;
  logic             out;
  logic             busy;
  logic             last;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  out,
    input  busy,
    input  last
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output out,
    output busy,
    output last
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: a WIDTH-bit word in over valid/ready, one bit per clock out.
// Optional gap-free streaming is enabled by defining BIT_SERIALIZER_BACK2BACK_EN.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  bit_serializer_if.slave bus
);

  localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned OutIdx = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ready, busy, out_bit, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    busy    = 1'b0;
    out_bit = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.valid) begin
          shreg_d = bus.data_in;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        busy    = 1'b1;
        // Only registered state feeds out, so data_in never reaches it combinationally.
        out_bit = shreg_q[OutIdx];
        last    = (cnt_q == '0);
        if (cnt_q != '0) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q - CntW'(1);
        end else begin
`ifdef BIT_SERIALIZER_BACK2BACK_EN
          ready = 1'b1;
          if (bus.valid) begin
            shreg_d = bus.data_in;
            cnt_d   = CntW'(WIDTH - 1);
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.out   = out_bit;
  assign bus.last  = last;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus
// stream; expected per-cycle outputs are queued as words are presented and popped each cycle.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct packed {
    logic out_m;
    logic out_l;
    logic last;
    logic busy;
    logic ready;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];

  bit_serializer_if #(.WIDTH(8)) bus_m ();
  bit_serializer_if #(.WIDTH(8)) bus_l ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input logic om, input logic ol, input logic l, input logic b,
                      input logic r);
    exp_t e;
    e.out_m = om;
    e.out_l = ol;
    e.last  = l;
    e.busy  = b;
    e.ready = r;
    sb.push_back(e);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      push(w[7-i], w[i], (i == 7), 1'b1, (i == 7) ? B2B : 1'b0);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Drive inputs for the next rising edge, then check outputs half a cycle after it.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    exp_t e;
    rst           = r;
    bus_m.valid   = v;
    bus_l.valid   = v;
    bus_m.data_in = d;
    bus_l.data_in = d;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow cyc=%0d: observed 0 entries expected >0", cyc);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("msb_out",   bus_m.out,   e.out_m);
      chk("msb_last",  bus_m.last,  e.last);
      chk("msb_busy",  bus_m.busy,  e.busy);
      chk("msb_ready", bus_m.ready, e.ready);
      chk("lsb_out",   bus_l.out,   e.out_l);
      chk("lsb_last",  bus_l.last,  e.last);
      chk("lsb_busy",  bus_l.busy,  e.busy);
      chk("lsb_ready", bus_l.ready, e.ready);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus_m.valid   = 1'b0;
    bus_l.valid   = 1'b0;
    bus_m.data_in = '0;
    bus_l.data_in = '0;

    // Reset held with valid high: nothing may be accepted.
    push_idle(2);
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b1, 8'hA5, 1'b1);

    // Single word A5; valid pulses mid-word must be ignored.
    push_word(8'hA5);
    push_idle(1);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Held valid: FF then 00.
    push_word(8'hFF);
    if (!B2B) push_idle(1);
    push_word(8'h00);
    push_idle(1);
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < (B2B ? 15 : 16); i++) cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // Reset on the 4th bit of FF, then 80 must serialize cleanly.
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push_idle(1);
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h80, 1'b1);
    push_word(8'h80);
    push_idle(1);
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector path. It accepts a WIDTH-bit word over a valid/ready handshake and emits the word one bit per clock on `out`, which drives the detector FSM's `in` directly. Between words `out` is held at 0, so the detector sees a clean, known idle level.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`, input, 1: single clock; all logic updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `data_in`, input, WIDTH: word to serialize; sampled only on an accept edge.
- `valid`, input, 1: upstream has a word on `data_in`.
- `ready`, output, 1: block can accept a word this cycle.
- `out`, output, 1: serial bit stream to the detector; 0 when not shifting.
- `busy`, output, 1: high while a word is being shifted (state SHIFT).
- `last`, output, 1: high during the cycle in which the final bit of a word is on `out`.

## Operation
- The block has two states, IDLE and SHIFT, and a shift register `shreg[WIDTH-1:0]`. It also has a down-counter `cnt` sized to $clog2(WIDTH) bits.
- **Accept:** a rising edge with `valid && ready` both high. Only on an accept is `data_in` sampled.
- **IDLE:**
  - Outputs: `ready`=1, `busy`=0, `out`=0, `last`=0.
  - On accept: load `shreg` with `data_in`, set `cnt`=WIDTH-1, and go to SHIFT.
- **SHIFT:**
  - Outputs: `busy`=1.
  - `out` = `shreg[WIDTH-1]` if MSB_FIRST, otherwise `shreg[0]`.
  - `last` = (`cnt`==0).
  - On each edge with `cnt`!=0: shift `shreg` by one toward the output end, zero-fill, and decrement `cnt`.
  - On the edge with `cnt`==0: go to IDLE, unless a back-to-back accept occurs (see Configuration).
- `ready` is a combinational function of state and `cnt` only. It never depends on `valid`.
- `data_in` changes and `valid` pulses while `ready`=0 are ignored. No word is lost or corrupted, and upstream must hold its word until accepted.
- `out` is driven from a register, so there is no combinational path from `data_in` to `out`.
- **Reset:**
  - `rst` high at a rising edge forces IDLE, `shreg`=0 and `cnt`=0, regardless of state.
  - A word in flight is discarded and `out` is 0 from the following cycle.
  - Reset has priority over an accept on the same edge.
  - Reset values: `ready`=1, `busy`=0, `out`=0, `last`=0.

## Timing
- **Latency:** the first bit of a word is on `out` in the cycle immediately after its accept edge.
- **Bit rate:** one bit per clock, for WIDTH consecutive cycles per word.
- `last` is asserted for exactly one cycle per word, coincident with bit WIDTH of that word.
- **Without back-to-back streaming:**
  - After the last bit there is exactly one IDLE cycle with `out`=0.
  - A word accepted on that cycle's edge starts the following cycle.
  - Minimum period is WIDTH+1 cycles per word.
- **With back-to-back streaming:** minimum period is WIDTH cycles per word, and there is no idle bit between words.

## Configuration
- **Macro:** `BIT_SERIALIZER_BACK2BACK_EN`.
- **Defined:**
  - `ready` is also 1 in SHIFT when `cnt`==0.
  - An accept on that edge reloads `shreg`, sets `cnt`=WIDTH-1 and stays in SHIFT.
  - The next word's first bit immediately follows the previous word's last bit.
- **Undefined:**
  - `ready` is 1 only in IDLE.
  - Every word is followed by at least one `out`=0 cycle.

## Test plan
- **Reset values:** hold `rst`=1 for 2 cycles with `valid`=1 → `ready`=1, `busy`=0, `out`=0 and `last`=0 throughout; no word is accepted.
- **MSB-first word:** WIDTH=8, MSB_FIRST=1, accept 8'hA5 → `out`=1,0,1,0,0,1,0,1 on cycles 1–8 after the accept; `last` high only on cycle 8; `busy` high on cycles 1–8.
- **LSB-first word:** MSB_FIRST=0, accept 8'hA5 → `out`=1,0,1,0,0,1,0,1 (bit 0 first).
- **Held valid, macro undefined:** hold `valid`=1 and present 8'hFF then 8'h00 → `out` shows eight 1s, one 0 gap, then eight 0s. With the macro defined → eight 1s immediately followed by eight 0s, and `ready` high on the `last` cycle.
- **Reset mid-word:** assert `rst` on the 4th bit of 8'hFF → `out`=0 from the next cycle and `ready`=1. The next accepted word 8'h80 then produces 1 followed by seven 0s.
- **Detector integration:** WIDTH=3 driving the detector, send 3'b010 then 3'b101 (macro defined) → detector `out` pulses on the final bit of each pattern, and on no other cycle.
